// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls one pipe across a 16-column grid, draws gap rows
// from a 4-bit LFSR, keeps score and runs the IDLE/RUN/OVER game FSM.
module pipe_scroller #(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned GAP_SIZE = 4,
    parameter int unsigned BIRD_X   = 12,
    parameter int unsigned GAP_INIT = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       collision,
    output logic [3:0] pipe_x,
    output logic [3:0] gap_y,
    output logic [7:0] score,
    output logic       step,
    output logic       running,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(TICK_DIV - 1);
    localparam logic [3:0] GAP_MAX   = 4'(16 - GAP_SIZE);
    localparam logic [3:0] GAP_DEC   = 4'(GAP_SIZE);
    localparam logic [3:0] BIRD_COL  = 4'(BIRD_X);
    localparam logic [3:0] GAP_RESET = 4'(GAP_INIT);
    localparam logic [3:0] LFSR_SEED = 4'b1001;

    state_t     state;
    logic [7:0] divider;
    logic [3:0] lfsr;
    logic [3:0] lfsr_next;
    logic [3:0] gap_next;

    // Next LFSR value (x^4+x^3+1) and the gap row folded into the legal range
    always_comb begin
        lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        gap_next  = (lfsr > GAP_MAX) ? (lfsr - GAP_DEC) : lfsr;
    end

    // Game FSM, scroll divider, pipe position, gap loads and score
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            divider   <= '0;
            lfsr      <= LFSR_SEED;
            pipe_x    <= '0;
            gap_y     <= GAP_RESET;
            score     <= '0;
            step      <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                        pipe_x    <= '0;
                        score     <= '0;
                        divider   <= '0;
                        gap_y     <= gap_next;
                        lfsr      <= lfsr_next;
                    end
                end
                RUN: begin
                    // Collision wins over a coincident step: nothing moves
                    if (collision) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
                        divider   <= '0;
                    end else if (divider == DIV_LAST) begin
                        divider <= '0;
                        step    <= 1'b1;
                        pipe_x  <= pipe_x + 4'd1;
                        if (pipe_x == BIRD_COL && score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                        if (pipe_x == 4'hF) begin
                            gap_y <= gap_next;
                            lfsr  <= lfsr_next;
                        end
                    end else begin
                        divider <= divider + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
